// File: rtl/axi4_lite_slv_reg_file_pkg.sv
// Shared types and helpers for the AXI4-Lite slave register file.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Byte-lane merge sized for the widest supported bus (64 bit);
  // narrower callers zero-extend their operands and truncate the result.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aix4_lite_if.sv
// AXI4-Lite bundle shared by the register file and whatever drives it.
interface aix4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport slv_port (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport mst_port (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave CSR block: NUM_RW_REGS software-written control registers
// followed by NUM_RO_REGS hardware status registers. Write and read channels
// run independent two-state FSMs, one transaction outstanding on each.
module axi4_lite_slv_reg_file
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int NUM_RW_REGS    = 2,
  parameter int NUM_RO_REGS    = 2
) (
  input  logic                                  i_clk,
  input  logic                                  i_async_rst_n,
  aix4_lite_if.slv_port                         if_s_axi,
  output logic [NUM_RW_REGS*DATA_BIT_WIDTH-1:0] o_rw_regs,
  output logic [NUM_RW_REGS-1:0]                o_wr_pulse,
  input  logic [NUM_RO_REGS*DATA_BIT_WIDTH-1:0] i_ro_regs
);

  localparam int STRB_W = DATA_BIT_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_BIT_WIDTH - LSB;

  // Register map must fit in the decoded word-index space.
  if (NUM_RW_REGS + NUM_RO_REGS > 2**IDX_W) begin : g_bad_map
    $error("axi4_lite_slv_reg_file: register map exceeds address space");
  end
  if (DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) begin : g_bad_width
    $error("axi4_lite_slv_reg_file: DATA_BIT_WIDTH must be 32 or 64");
  end

  // Reset synchroniser: assertion is immediate, release aligns to i_clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) rst_sync_q <= 2'b00;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // ---------------- write path ----------------
  wr_state_t                                   wstate_q, wstate_d;
  logic                                        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [IDX_W-1:0]                            aw_idx_q, aw_idx_d;
  logic [DATA_BIT_WIDTH-1:0]                   wdata_q, wdata_d;
  logic [STRB_W-1:0]                           wstrb_q, wstrb_d;
  logic                                        bvalid_q, bvalid_d;
  axi_resp_t                                   bresp_q, bresp_d;
  logic [NUM_RW_REGS-1:0][DATA_BIT_WIDTH-1:0]  rw_regs_q, rw_regs_d;
  logic [NUM_RW_REGS-1:0]                      wr_pulse_q, wr_pulse_d;
  logic                                        awready, wready, aw_hs, w_hs;
  logic [IDX_W-1:0]                            cur_idx;
  logic [DATA_BIT_WIDTH-1:0]                   cur_data;
  logic [STRB_W-1:0]                           cur_strb;

  assign awready = (wstate_q == W_COLLECT) && !aw_got_q;
  assign wready  = (wstate_q == W_COLLECT) && !w_got_q;

  // Collect AW/W in any order, commit once both are held, then hold B until accepted.
  always_comb begin
    wstate_d   = wstate_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rw_regs_d  = rw_regs_q;
    wr_pulse_d = '0;
    aw_hs      = if_s_axi.awvalid && awready;
    w_hs       = if_s_axi.wvalid && wready;
    cur_idx    = aw_got_q ? aw_idx_q : if_s_axi.awaddr[ADDR_BIT_WIDTH-1:LSB];
    cur_data   = w_got_q ? wdata_q : if_s_axi.wdata;
    cur_strb   = w_got_q ? wstrb_q : if_s_axi.wstrb;
    if (wstate_q == W_COLLECT) begin
      if (aw_hs) begin
        aw_got_d = 1'b1;
        aw_idx_d = if_s_axi.awaddr[ADDR_BIT_WIDTH-1:LSB];
      end
      if (w_hs) begin
        w_got_d = 1'b1;
        wdata_d = if_s_axi.wdata;
        wstrb_d = if_s_axi.wstrb;
      end
      if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
        wstate_d = W_RESP;
        bvalid_d = 1'b1;
        bresp_d  = RESP_SLVERR;
        for (int k = 0; k < NUM_RW_REGS; k++) begin
          if (32'(cur_idx) == 32'(k)) begin
            rw_regs_d[k]  = DATA_BIT_WIDTH'(strb_merge(64'(rw_regs_q[k]), 64'(cur_data),
                                                       8'(cur_strb)));
            wr_pulse_d[k] = |cur_strb;
            bresp_d       = RESP_OKAY;
          end
        end
      end
    end else if (if_s_axi.bready) begin
      wstate_d = W_COLLECT;
      bvalid_d = 1'b0;
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
    end
  end

  // Write-path state register.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q   <= W_COLLECT;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rw_regs_q  <= '0;
      wr_pulse_q <= '0;
    end else begin
      wstate_q   <= wstate_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rw_regs_q  <= rw_regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // ---------------- read path ----------------
  rd_state_t                 rstate_q, rstate_d;
  logic                      rvalid_q, rvalid_d;
  logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;
  axi_resp_t                 rresp_q, rresp_d;
  logic [IDX_W-1:0]          ar_idx;

  // Capture data at the AR handshake (pre-write register values), hold until R is accepted.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    ar_idx   = if_s_axi.araddr[ADDR_BIT_WIDTH-1:LSB];
    if (rstate_q == R_IDLE) begin
      if (if_s_axi.arvalid) begin
        rstate_d = R_DATA;
        rvalid_d = 1'b1;
        rdata_d  = '0;
        rresp_d  = RESP_SLVERR;
        for (int k = 0; k < NUM_RW_REGS; k++) begin
          if (32'(ar_idx) == 32'(k)) begin
            rdata_d = rw_regs_q[k];
            rresp_d = RESP_OKAY;
          end
        end
        for (int k = 0; k < NUM_RO_REGS; k++) begin
          if (32'(ar_idx) == 32'(NUM_RW_REGS + k)) begin
            rdata_d = i_ro_regs[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
            rresp_d = RESP_OKAY;
          end
        end
      end
    end else if (if_s_axi.rready) begin
      rstate_d = R_IDLE;
      rvalid_d = 1'b0;
    end
  end

  // Read-path state register.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign if_s_axi.awready = awready;
  assign if_s_axi.wready  = wready;
  assign if_s_axi.bvalid  = bvalid_q;
  assign if_s_axi.bresp   = bresp_q;
  assign if_s_axi.arready = (rstate_q == R_IDLE);
  assign if_s_axi.rvalid  = rvalid_q;
  assign if_s_axi.rdata   = rdata_q;
  assign if_s_axi.rresp   = rresp_q;
  assign o_rw_regs        = rw_regs_q;
  assign o_wr_pulse       = wr_pulse_q;

  // Byte-offset address bits and protection attributes carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{if_s_axi.awaddr[LSB-1:0], if_s_axi.araddr[LSB-1:0],
                       if_s_axi.awprot, if_s_axi.arprot};

endmodule
